// File: rtl/bnn_fc_score.sv
// bnn_fc_score: XNOR-popcount scoring of two output neurons, scaled and saturated to signed scores.
module bnn_fc_score #(
  parameter int P         = 8,
  parameter int NUM_BEATS = 8,
  parameter int SCORE_W   = 4,
  parameter int SHIFT     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [P-1:0]       act,
  input  logic [P-1:0]       w0,
  input  logic [P-1:0]       w1,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic               out_valid,
  output logic               len_err
);
  localparam int N  = P * NUM_BEATS;
  localparam int AW = $clog2(N + 1);
  localparam int DW = AW + 2;
  localparam int CW = $clog2(NUM_BEATS + 1);
  localparam logic signed [DW-1:0] SMAX = DW'(2 ** (SCORE_W - 1) - 1);
  localparam logic signed [DW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   acc0, acc1;
  logic [CW-1:0]   beat_cnt;
  logic            miss_q, err_q;
  logic            accept, final_beat;

  function automatic logic [AW-1:0] pop(input logic [P-1:0] v);
    pop = '0;
    for (int i = 0; i < P; i++) pop = pop + AW'(v[i]);
  endfunction

  // bipolar dot = 2*matches - N, floored by the shift, then clamped to the score range
  function automatic logic [SCORE_W-1:0] sat(input logic [AW-1:0] a);
    logic signed [DW-1:0] d, s;
    d = $signed({1'b0, a, 1'b0}) - $signed(DW'(N));
    s = d >>> SHIFT;
    sat = s > SMAX ? SCORE_W'(SMAX) : s < SMIN ? SCORE_W'(SMIN) : s[SCORE_W-1:0];
  endfunction

  assign in_ready   = state == IDLE || state == ACCUM;
  assign accept     = in_valid && in_ready;
  assign final_beat = beat_cnt == CW'(NUM_BEATS - 1);
  assign out_valid  = state == OUT;
  assign len_err    = err_q || (state == OUT && miss_q);

  always_comb begin
    state_n = state;
    if (accept) state_n = final_beat ? SCALE : in_last ? IDLE : ACCUM;
    else if (state == SCALE) state_n = OUT;
    else if (state == OUT) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc0     <= '0;
      acc1     <= '0;
      beat_cnt <= '0;
      score0   <= '0;
      score1   <= '0;
      miss_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= accept && in_last && !final_beat;
      if (accept) begin
        acc0     <= (state == IDLE ? '0 : acc0) + pop(~(act ^ w0));
        acc1     <= (state == IDLE ? '0 : acc1) + pop(~(act ^ w1));
        beat_cnt <= (final_beat || in_last) ? '0 : beat_cnt + 1'b1;
        miss_q   <= !in_last;
        if (in_last && !final_beat) begin
          acc0 <= '0;
          acc1 <= '0;
        end
      end
      if (state == SCALE) begin
        score0 <= sat(acc0);
        score1 <= sat(acc1);
        acc0   <= '0;
        acc1   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bnn_fc_score.sv
// tb_bnn_fc_score: table vectors, handshake corner cases and random frames against a bipolar dot-product model.
module tb_bnn_fc_score;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_last, out_valid, len_err;
  logic [7:0] act, w0, w1;
  logic [3:0] score0, score1;
  int checks = 0, errors = 0;
  logic [7:0] fa[8], f0[8], f1[8];

  typedef struct {
    logic [7:0] a, w0, w1, w1b;
    int split, gap_at, gap_len, last_at, e0, e1, eerr;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  bnn_fc_score dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .act(act), .w0(w0), .w1(w1), .score0(score0), .score1(score1),
    .out_valid(out_valid), .len_err(len_err)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // each bit contributes +1 on agreement and -1 otherwise; result floored by 8 and clamped to 4-bit signed
  function automatic int model(input int cls);
    int dot, q;
    logic [7:0] w;
    dot = 0;
    for (int i = 0; i < 8; i++) begin
      w = cls != 0 ? f1[i] : f0[i];
      for (int b = 0; b < 8; b++) dot += (fa[i][b] == w[b]) ? 1 : -1;
    end
    q = dot / 8;
    if (dot < 0 && dot % 8 != 0) q--;
    return q > 7 ? 7 : q < -8 ? -8 : q;
  endfunction

  task automatic send_beats(input int n, input int last_at, input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        repeat (gap_len) tick();
      end
      in_valid = 1'b1;
      act      = fa[i];
      w0       = f0[i];
      w1       = f1[i];
      in_last  = (i == last_at);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int e0, input int e1, input int eerr);
    int n;
    n = 0;
    chk({tag, " ready_scale"}, int'(in_ready), 0);
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, n, 1);
    chk({tag, " score0"}, int'($signed(score0)), e0);
    chk({tag, " score1"}, int'($signed(score1)), e1);
    chk({tag, " len_err"}, int'(len_err), eerr);
    chk({tag, " ready_out"}, int'(in_ready), 0);
    tick();
    chk({tag, " valid_pulse"}, int'(out_valid), 0);
    chk({tag, " ready_back"}, int'(in_ready), 1);
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] x0, input logic [7:0] x1);
    for (int i = 0; i < 8; i++) begin
      fa[i] = a;
      f0[i] = x0;
      f1[i] = x1;
    end
  endtask

  initial begin
    int pulses, r;
    logic [7:0] sp;
    tbl[0] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8, 8, 0, 7,  7, -8, 0};
    tbl[1] = '{8'hFF, 8'h0F, 8'h3F, 8'h3F, 8, 8, 0, 7,  0,  4, 0};
    tbl[2] = '{8'hFF, 8'h0F, 8'h3F, 8'h3F, 8, 4, 3, 7,  0,  4, 0};
    tbl[3] = '{8'hFF, 8'h0F, 8'h3F, 8'h00, 5, 8, 0, 7,  0, -1, 0};
    tbl[4] = '{8'hFF, 8'h0F, 8'h3F, 8'h3F, 8, 8, 0, -1, 0,  4, 1};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; act = '0; w0 = '0; w1 = '0;
    repeat (2) tick();
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst len_err", int'(len_err), 0);
    chk("rst score0", int'(score0), 0);
    chk("rst score1", int'(score1), 0);
    rst = 1'b0;
    tick();

    foreach (tbl[k]) begin
      for (int i = 0; i < 8; i++) begin
        fa[i] = tbl[k].a;
        f0[i] = tbl[k].w0;
        f1[i] = i >= tbl[k].split ? tbl[k].w1b : tbl[k].w1;
      end
      send_beats(8, tbl[k].last_at, tbl[k].gap_at, tbl[k].gap_len);
      expect_out($sformatf("vec%0d", k), tbl[k].e0, tbl[k].e1, tbl[k].eerr);
      tick();
    end

    fill(8'hFF, 8'hFF, 8'h00);
    send_beats(3, 2, 8, 0);
    chk("early len_err", int'(len_err), 1);
    chk("early out_valid", int'(out_valid), 0);
    tick();
    chk("early len_err pulse", int'(len_err), 0);
    pulses = 0;
    repeat (5) begin
      pulses += int'(out_valid);
      tick();
    end
    chk("early no_out", pulses, 0);
    chk("early keep score0", int'($signed(score0)), 0);
    chk("early keep score1", int'($signed(score1)), 4);
    send_beats(8, 7, 8, 0);
    expect_out("after_early", 7, -8, 0);

    fill(8'hFF, 8'h0F, 8'h3F);
    send_beats(8, 7, 8, 0);
    in_valid = 1'b1; act = 8'h00; w0 = 8'h00; w1 = 8'hFF; in_last = 1'b0;
    expect_out("held_first", 0, 4, 0);
    fill(8'h00, 8'h00, 8'hFF);
    send_beats(8, 7, 8, 0);
    expect_out("held_second", 7, -8, 0);

    fill(8'hFF, 8'hFF, 8'h00);
    send_beats(5, -1, 8, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst score0", int'(score0), 0);
    chk("midrst score1", int'(score1), 0);
    chk("midrst in_ready", int'(in_ready), 1);
    chk("midrst out_valid", int'(out_valid), 0);
    fill(8'hFF, 8'h0F, 8'h0F);
    send_beats(8, 7, 8, 0);
    expect_out("post_rst", 0, 0, 0);

    for (int f = 0; f < 20; f++) begin
      r = $urandom_range(0, 2);
      for (int i = 0; i < 8; i++) begin
        fa[i] = 8'($urandom);
        sp    = 8'($urandom & $urandom & $urandom);
        f0[i] = r == 0 ? 8'($urandom) : r == 1 ? fa[i] ^ sp : ~fa[i] ^ sp;
        sp    = 8'($urandom & $urandom);
        f1[i] = r == 2 ? fa[i] ^ sp : 8'($urandom);
      end
      send_beats(8, 7, $urandom_range(0, 9), $urandom_range(1, 3));
      expect_out($sformatf("rand%0d", f), model(0), model(1), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
